// File: rtl/preamble_sync_pkg.sv
// Shared types and default constants for the preamble synchroniser.
// The state names match the HUNT / GOT0 / LOCKED acquisition phases.
package preamble_sync_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        GOT0   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]  DEF_PAT0    = 8'h55;
    localparam logic [7:0]  DEF_PAT1    = 8'hD5;
    localparam int unsigned DEF_REP     = 5;
    localparam int unsigned DEF_TIMEOUT = 16;

    // Width of the idle timer and of the header statistics counter.
    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/preamble_sat_cnt.sv
// Saturating up-counter. Clear has priority over increment.
// The count holds at all-ones once it gets there.
module preamble_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/preamble_sync.sv
// Preamble synchroniser: locks after REP back-to-back PAT0/PAT1 pairs and drops lock
// after TIMEOUT idle cycles. Define PREAMBLE_SYNC_STATS_EN to enable the hdr_total counter.
module preamble_sync
    import preamble_sync_pkg::*;
#(
    parameter int unsigned   DW      = 8,
    parameter logic [DW-1:0] PAT0    = DW'(DEF_PAT0),
    parameter logic [DW-1:0] PAT1    = DW'(DEF_PAT1),
    parameter int unsigned   REP     = DEF_REP,
    parameter int unsigned   TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din_vld,
    input  logic [DW-1:0] din,
    input  logic          clear,
    output logic          hdr_det,
    output logic          locked,
    output logic          lost,
    output logic [7:0]    run_cnt,
    output logic [15:0]   hdr_total
);

    localparam logic [7:0]       REP_W    = 8'(REP);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_d;
    logic [7:0]       r_run_cnt;
    logic [7:0]       w_run_cnt_d;
    logic [7:0]       w_run_inc;
    logic             r_hdr_det;
    logic             w_hdr_det_d;
    logic             r_locked;
    logic             r_lost;
    logic             w_lost_d;
    logic             w_is_pat0;
    logic             w_is_pat1;
    logic [CNT_W-1:0] w_idle;
    logic             w_idle_clr;
    logic             w_idle_inc;

    assign w_is_pat0 = (din == PAT0);
    assign w_is_pat1 = (din == PAT1);
    assign w_run_inc = r_run_cnt + 8'd1;

    always_comb begin
        w_state_d   = r_state;
        w_run_cnt_d = r_run_cnt;
        w_hdr_det_d = 1'b0;
        w_lost_d    = 1'b0;
        if (clear) begin
            w_state_d   = HUNT;
            w_run_cnt_d = 8'd0;
        end else begin
            case (r_state)
                HUNT: begin
                    if (din_vld) begin
                        if (w_is_pat0) begin
                            w_state_d = GOT0;
                        end else begin
                            w_run_cnt_d = 8'd0;
                        end
                    end
                end
                GOT0: begin
                    if (din_vld) begin
                        if (w_is_pat1) begin
                            w_run_cnt_d = w_run_inc;
                            if (w_run_inc == REP_W) begin
                                w_state_d   = LOCKED;
                                w_hdr_det_d = 1'b1;
                            end else begin
                                w_state_d = HUNT;
                            end
                        end else if (w_is_pat0) begin
                            // A repeated PAT0 restarts the run with itself as the new first word.
                            w_run_cnt_d = 8'd0;
                        end else begin
                            w_state_d   = HUNT;
                            w_run_cnt_d = 8'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (!din_vld && (w_idle == TMO_LAST)) begin
                        w_state_d   = HUNT;
                        w_run_cnt_d = 8'd0;
                        w_lost_d    = 1'b1;
                    end
                end
                default: begin
                    w_state_d   = HUNT;
                    w_run_cnt_d = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= HUNT;
            r_run_cnt <= 8'd0;
            r_hdr_det <= 1'b0;
            r_locked  <= 1'b0;
            r_lost    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_run_cnt <= w_run_cnt_d;
            r_hdr_det <= w_hdr_det_d;
            r_locked  <= (w_state_d == LOCKED);
            r_lost    <= w_lost_d;
        end
    end

    // The idle timer only runs while locked; it sits at zero everywhere else.
    assign w_idle_clr = clear || (r_state != LOCKED) || din_vld || w_lost_d;
    assign w_idle_inc = (r_state == LOCKED) && !din_vld;

    preamble_sat_cnt #(
        .W (CNT_W)
    ) u_idle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_idle_clr),
        .i_inc (w_idle_inc),
        .o_cnt (w_idle)
    );

`ifdef PREAMBLE_SYNC_STATS_EN
    logic [CNT_W-1:0] w_hdr_total;

    preamble_sat_cnt #(
        .W (CNT_W)
    ) u_hdr_total_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (1'b0),
        .i_inc (w_hdr_det_d),
        .o_cnt (w_hdr_total)
    );

    assign hdr_total = w_hdr_total;
`else
    assign hdr_total = 16'd0;
`endif

    assign hdr_det = r_hdr_det;
    assign locked  = r_locked;
    assign lost    = r_lost;
    assign run_cnt = r_run_cnt;

endmodule
